// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: coordinates, encoder control (VDE/CD), strobes and bring-up pattern.
// The generator drives it through the master modport; consumers attach through slave.
interface video_timing_gen_if;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        VDE;
    logic [1:0]  CD;
    logic        line_start;
    logic        frame_start;
    logic [23:0] pattern_rgb;

    modport master (
        output hcount, vcount, VDE, CD, line_start, frame_start, pattern_rgb
    );

    modport slave (
        input hcount, vcount, VDE, CD, line_start, frame_start, pattern_rgb
    );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster counter with registered VDE / sync / strobe decode for the TMDS encoders.
// Optional 8-bar colour pattern on pattern_rgb when VTG_TEST_PATTERN_EN is defined.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic                  pixclk,
    input  logic                  rst,
    video_timing_gen_if.master    vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Region bounds are 11 bits so a region ending exactly at 1024 cannot wrap.
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_vde;
    logic [1:0] r_cd;
    logic       r_line_start;
    logic       r_frame_start;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_hcount_next;
    logic [9:0] w_vcount_next;
    logic       w_vde_next;
    logic       w_hsync_next;
    logic       w_vsync_next;
    logic       w_line_start_next;
    logic       w_frame_start_next;

    // Outputs are decoded from the count about to be registered, so every
    // registered output lines up with the coordinates presented alongside it.
    always_comb begin
        w_h_wrap      = (r_hcount == H_LAST);
        w_v_wrap      = (r_vcount == V_LAST);
        w_hcount_next = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
        w_vcount_next = r_vcount;
        if (w_h_wrap) begin
            w_vcount_next = w_v_wrap ? 10'd0 : r_vcount + 10'd1;
        end

        w_vde_next = ({1'b0, w_hcount_next} < H_ACT) && ({1'b0, w_vcount_next} < V_ACT);

        w_hsync_next = ~HS_POL;
        if (({1'b0, w_hcount_next} >= HS_START) && ({1'b0, w_hcount_next} < HS_END)) begin
            w_hsync_next = HS_POL;
        end

        w_vsync_next = ~VS_POL;
        if (({1'b0, w_vcount_next} >= VS_START) && ({1'b0, w_vcount_next} < VS_END)) begin
            w_vsync_next = VS_POL;
        end

        w_line_start_next  = (w_hcount_next == 10'd0);
        w_frame_start_next = w_line_start_next && (w_vcount_next == 10'd0);
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            r_hcount      <= H_LAST;
            r_vcount      <= V_LAST;
            r_vde         <= 1'b0;
            r_cd          <= {~VS_POL, ~HS_POL};
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_next;
            r_vcount      <= w_vcount_next;
            r_vde         <= w_vde_next;
            r_cd          <= {w_vsync_next, w_hsync_next};
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    assign vid.hcount      = r_hcount;
    assign vid.vcount      = r_vcount;
    assign vid.VDE         = r_vde;
    assign vid.CD          = r_cd;
    assign vid.line_start  = r_line_start;
    assign vid.frame_start = r_frame_start;

`ifdef VTG_TEST_PATTERN_EN
    localparam int         BAR_W    = H_ACTIVE / 8;
    localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

    logic [23:0] w_bar_lut [8];
    logic [2:0]  r_bar_idx;
    logic [9:0]  r_bar_sub;
    logic [23:0] r_pattern_rgb;
    logic [2:0]  w_bar_idx_next;
    logic [9:0]  w_bar_sub_next;

    // Bar colours are the inverted index bits: R = ~idx[1], G = ~idx[2], B = ~idx[0].
    for (genvar gi = 0; gi < 8; gi++) begin : g_bar_lut
        localparam logic [2:0] IDX = 3'(gi);
        assign w_bar_lut[gi] = {{8{~IDX[1]}}, {8{~IDX[2]}}, {8{~IDX[0]}}};
    end

    always_comb begin
        w_bar_idx_next = r_bar_idx;
        w_bar_sub_next = r_bar_sub + 10'd1;
        if (w_hcount_next == 10'd0) begin
            w_bar_idx_next = 3'd0;
            w_bar_sub_next = 10'd0;
        end else if (r_bar_sub == BAR_LAST) begin
            w_bar_idx_next = r_bar_idx + 3'd1;
            w_bar_sub_next = 10'd0;
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            r_bar_idx     <= 3'd0;
            r_bar_sub     <= 10'd0;
            r_pattern_rgb <= 24'h000000;
        end else begin
            r_bar_idx     <= w_bar_idx_next;
            r_bar_sub     <= w_bar_sub_next;
            r_pattern_rgb <= w_vde_next ? w_bar_lut[w_bar_idx_next] : 24'h000000;
        end
    end

    assign vid.pattern_rgb = r_pattern_rgb;
`else
    assign vid.pattern_rgb = 24'h000000;
`endif

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator for the HDMI output path. Runs on the pixel clock, walks a horizontal/vertical pixel counter over the full frame (active plus blanking), and drives the `VDE` and `CD` inputs of the per-channel TMDS encoders. It also supplies pixel coordinates and line/frame strobes to the Tetris renderer. An optional colour-bar pattern is provided for bring-up.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HS_POL`, 0: hsync asserted level (0 = active-low)
- `VS_POL`, 0: vsync asserted level (0 = active-low)
- `pixclk`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `hcount`  out  10  current pixel column, 0..H_TOTAL-1
- `vcount`  out  10  current line, 0..V_TOTAL-1
- `VDE`  out  1  video data enable; 1 when hcount < H_ACTIVE and vcount < V_ACTIVE
- `CD`  out  2  control data to the encoders; {vsync, hsync} at line levels
- `line_start`  out  1  one-cycle pulse when hcount == 0
- `frame_start`  out  1  one-cycle pulse when hcount == 0 and vcount == 0
- `pattern_rgb`  out  24  {R,G,B} colour-bar pixel; see Configuration

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024.
- hcount increments every pixclk. At H_TOTAL-1 it wraps to 0, and vcount increments in the same edge.
- vcount wraps from V_TOTAL-1 to 0 on the edge where hcount also wraps.
- Horizontal sync region: H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
  - hsync = HS_POL inside the region, ~HS_POL outside.
- Vertical sync region: V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
  - vsync = VS_POL inside the region, ~VS_POL outside.
  - vsync changes only on edges where hcount becomes 0; it covers whole lines.
- `CD[1]` = vsync and `CD[0]` = hsync at all times, including during active video.
- All outputs are registered. Every output describes the same (hcount, vcount) pair presented in that cycle; there is no skew between coordinates and strobes.
- The counter is free-running. The block has no enable, no backpressure, and no stall.

## Timing
- Reset, held for any number of cycles:
  - hcount = H_TOTAL-1 and vcount = V_TOTAL-1 (last blanking pixel)
  - VDE = 0, CD = {~VS_POL, ~HS_POL} (2'b11 by default)
  - line_start = 0, frame_start = 0, pattern_rgb = 0
- First edge after rst falls: hcount = 0, vcount = 0, VDE = 1, line_start = 1, frame_start = 1.
- rst asserted mid-frame: takes effect on the next edge with the reset values above. No partial line or sync pulse continues past that edge.
- Latency is zero relative to the counters; each output is a registered decode of the count being presented.
- Default frame is exactly 420000 pixclk cycles. line_start period is 800 cycles, and frame_start period is 420000 cycles.
- Every line carries exactly 96 hsync-asserted cycles. Every frame carries exactly 2 vsync-asserted lines (1600 cycles).

## Configuration
- Macro: `VTG_TEST_PATTERN_EN`.
- Defined:
  - pattern_rgb carries 8 vertical bars, each BAR_W = H_ACTIVE/8 pixels wide.
  - Bar order, left to right: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Bar selection uses a 3-bit bar index plus a per-line sub-counter; no divider.
  - Both counters reset to 0 at hcount == 0.
  - pattern_rgb = 0 whenever VDE = 0. It is registered and aligned with VDE.
- Undefined: the pattern logic is absent and pattern_rgb is tied to 24'h000000.

## Test plan
- Release reset, run 1 cycle -> hcount = 0, vcount = 0, VDE = 1, frame_start = 1, CD = 2'b11.
- Run line 0 -> VDE falls at hcount = 640. CD[0] = 0 for hcount 656..751 exactly, then returns to 1. hcount wraps 799→0 and vcount becomes 1 with line_start = 1.
- Run a full frame -> vsync low only for vcount 490..491, with edges at hcount = 0. Next frame_start occurs exactly 420000 cycles after the first. VDE high count per frame = 307200.
- Assert rst for 1 cycle at hcount = 300, vcount = 200 -> next cycle shows the reset values. The cycle after shows (0,0) with frame_start = 1.
- With HS_POL = 1 and VS_POL = 1 -> CD = 2'b00 in reset and blanking. CD[0] = 1 only for hcount 656..751, and CD[1] = 1 only for vcount 490..491.
- With `VTG_TEST_PATTERN_EN` -> pattern_rgb = FFFFFF at hcount 0..79, FFFF00 at 80..159, ..., 000000 at 560..639, and 0 at hcount ≥ 640. Without the macro, pattern_rgb is constant 0.
